alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL provide ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-004 The block SHALL provide ports req0_ready / req1_ready, output, 1 bit each: the operation is accepted this cycle when valid and ready are both 1.
REQ-005 The block SHALL provide ports req0_op / req1_op, input, 3 bits: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 signed less-than, 7 reserved.
REQ-006 The block SHALL provide ports req0_a, req0_b, req1_a, req1_b, input, 4 bits each: two's-complement operands.
REQ-007 The block SHALL provide port rsp_valid, output, 1 bit: a response is held on the rsp_* outputs.
REQ-008 The block SHALL provide port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-009 The block SHALL provide port rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-010 The block SHALL provide ports rsp_result (4 bits), rsp_overflow (1 bit) and rsp_zero (1 bit), outputs: the registered ALU outputs.
REQ-011 The block SHALL provide port ovf_clr, input, 1 bit: synchronous clear of ovf_cnt.
REQ-012 The block SHALL provide port ovf_cnt, output, 8 bits: saturating count of responses that carried overflow.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, RESP.
- IDLE -> EXEC on handshake.
- EXEC -> RESP unconditionally after 1 cycle.
- RESP -> IDLE when rsp_ready is 1.
REQ-014 req*_ready SHALL be 1 only in IDLE, and only for the granted port; ready may depend combinationally on req*_valid.
REQ-015 Arbitration SHALL be round-robin using a 1-bit pointer.
- Only one port valid: that port is granted.
- Both ports valid: the port named by the pointer is granted.
- After any grant, the pointer becomes the other port.
REQ-016 On handshake, op, a, b and the port id SHALL be latched; requester inputs are then ignored until the FSM returns to IDLE.
REQ-017 In EXEC, the latched operands SHALL be evaluated and the result, overflow and zero registered, so rsp_valid rises 2 cycles after the handshake cycle.
REQ-018 ADD and SUB SHALL be computed on 5-bit sign-extended operands.
- Overflow occurs when bit 4 of the sum differs from bit 3.
- On overflow: result = 0 and overflow = 1.
REQ-019 NOT SHALL return ~a, AND returns a&b, OR returns a|b, XOR returns a^b, and overflow SHALL be 0 for all four.
REQ-020 Signed less-than SHALL return 4'b0001 if a<b (signed) and 0 otherwise; op 7 SHALL return 0; overflow SHALL be 0 for both.
REQ-021 zero SHALL be 1 exactly when result == 0, including the overflow case.
REQ-022 rsp_* outputs SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-023 rsp_valid SHALL fall in the cycle after acceptance.
REQ-024 A new grant SHALL occur no earlier than the cycle after RESP exits, giving a peak throughput of 1 operation per 3 cycles.
REQ-025 ovf_cnt SHALL increment by 1 on each accepted response (rsp_valid & rsp_ready) whose overflow is 1, and SHALL saturate at 255.
REQ-026 ovf_clr SHALL take priority over a simultaneous increment, leaving ovf_cnt = 0.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL reset as follows:
- FSM = IDLE
- pointer = 0
- rsp_valid = 0
- rsp_result = 0, rsp_overflow = 0, rsp_zero = 0, rsp_id = 0
- ovf_cnt = 0
- req*_ready = 0 during the reset cycle
REQ-028 A reset asserted in EXEC or RESP SHALL abort the in-flight operation with no response and no counter update.

Structure
REQ-029 A shared package SHALL hold:
- the opcode constants (3-bit, values per REQ-005)
- the FSM state encoding
- the operand width parameter (4)
REQ-030 The evaluation SHALL be one combinational sub-module, alu4_core, with inputs op, a, b and outputs result, overflow, zero, instantiated once; all registers SHALL live in alu_arb.

Verification
REQ-031 Single ADD: req0 op=0, a=3, b=4 -> req0_ready in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, result=7, overflow=0, zero=0.
REQ-032 Overflow: req1 op=0, a=7, b=1 -> result=0, overflow=1, zero=1; on accept, ovf_cnt increments by 1. Then op=1, a=-8, b=1 -> overflow=1.
REQ-033 Contention: both ports valid continuously after reset -> grants alternate 0,1,0,1 and each rsp_id matches its grant.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles during RESP -> outputs stable, no new grant; the cycle after rsp_ready=1, rsp_valid=0.
REQ-035 Compare, NOT, and op 7:
- op=6, a=-2, b=1 -> result 1
- op=6, a=1, b=-2 -> result 0
- op=2, a=4'b1111 -> result 0, zero=1
- op=7 -> result 0
REQ-036 Reset and saturation:
- rst_n=0 during EXEC -> no response, ready returns in IDLE with pointer=0.
- 256 overflow responses -> ovf_cnt=255.
- ovf_clr concurrent with an increment -> ovf_cnt=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port arbitrated ALU: operand width, opcodes and FSM encoding.
package alu_arb_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_alu4_core.sv
// Purely combinational ALU evaluating one latched operation; overflowing ADD/SUB yields zero.
module alu4_core
    import alu_arb_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              overflow_o,
    output logic              zero_o
);

    logic signed [DATA_W:0] a_ext;
    logic signed [DATA_W:0] b_ext;
    logic signed [DATA_W:0] sum;

    // Force an overflowed sum to zero so the flag and zero output agree.
    function automatic logic [DATA_W:0] sat_wrap(input logic [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return {1'b1, {DATA_W{1'b0}}};
        end
        return {1'b0, s[DATA_W-1:0]};
    endfunction

    always_comb begin
        a_ext      = $signed({a_i[DATA_W-1], a_i});
        b_ext      = $signed({b_i[DATA_W-1], b_i});
        sum        = '0;
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                sum = a_ext + b_ext;
                {overflow_o, result_o} = sat_wrap(sum);
            end
            OP_SUB: begin
                sum = a_ext - b_ext;
                {overflow_o, result_o} = sat_wrap(sum);
            end
            OP_NOT: result_o = ~a_i;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end to a shared ALU with a registered, backpressured
// response and a saturating overflow counter.
module alu_arb
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    input  logic              ovf_clr,
    output logic [7:0]        ovf_cnt
);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf, alu_zero;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    alu4_core u_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .result_o   (alu_res),
        .overflow_o (alu_ovf),
        .zero_o     (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt0 = req0_valid & (~req1_valid | ~ptr_q);
                gnt1 = req1_valid & (~req0_valid |  ptr_q);
                if (gnt0 | gnt1) begin
                    state_d = ST_EXEC;
                    ptr_d   = gnt0;
                    id_d    = gnt1;
                    op_d    = gnt1 ? req1_op : req0_op;
                    a_d     = gnt1 ? req1_a  : req0_a;
                    b_d     = gnt1 ? req1_b  : req0_b;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                res_d   = alu_res;
                ovf_d   = alu_ovf;
                zero_d  = alu_zero;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear wins over an increment landing in the same cycle.
        if (ovf_clr) begin
            cnt_d = 8'd0;
        end else if ((state_q == ST_RESP) && rsp_ready && ovf_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are only consumed after a handshake, so they need no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign req0_ready   = gnt0 & rst_n;
    assign req1_ready   = gnt1 & rst_n;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign ovf_cnt      = cnt_q;

endmodule
